sr_latch_monitor: RTL

Synchronous checker that sits on the output side of an SR latch under test. It samples the latch's S/R inputs and its Q/Qn outputs every clock and tracks the state the latch should hold. It flags output mismatches, complement violations and forbidden S=R=1 commands, and keeps saturating event counters. It is synthesizable and is used alongside latch/flip-flop benches and on-board self-test, in place of eyeballing waveforms.

---
 rtl/sr_pkg.sv | 21 ++
 rtl/sat_counter.sv | 26 ++
 rtl/sr_latch_monitor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared types for SR latch / flip-flop checkers: model state and S/R command codes.
package sr_pkg;

    // Model of what the latch under test should be holding
    typedef enum logic [1:0] {
        StUnknown = 2'b00,
        StSet     = 2'b01,
        StClr     = 2'b10
    } latch_state_e;

    // {S,R} command encodings
    localparam logic [1:0] CmdHold   = 2'b00;
    localparam logic [1:0] CmdReset  = 2'b01;
    localparam logic [1:0] CmdSet    = 2'b10;
    localparam logic [1:0] CmdForbid = 2'b11;

    function automatic logic [1:0] pack_cmd(input logic s, input logic r);
        return {s, r};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // Count up on i_inc, holding at all-ones instead of wrapping
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + One;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sr_latch_monitor.sv
// Checker for an SR latch: tracks the expected state from sampled S/R, compares the
// DUT's Q/Qn after SETTLE cycles, and counts errors, forbidden commands and checks.
module sr_latch_monitor
    import sr_pkg::*;
#(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_s,
    input  logic             i_r,
    input  logic             i_q,
    input  logic             i_qn,
    input  logic             i_en,
    output logic             o_exp_q,
    output logic             o_exp_valid,
    output logic             o_mismatch,
    output logic             o_comp_err,
    output logic             o_forbidden,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_forb_count,
    output logic [CNT_W-1:0] o_chk_count
);

    latch_state_e r_state;
    latch_state_e w_state_next;
    logic         r_exp_q;
    logic         r_exp_valid;
    logic [1:0]   w_cmd;
    logic         w_next_valid;
    logic         w_next_q;

    // Stage 0 holds the expectation formed at the same edge as r_state, so the last
    // stage lines up with Q sampled SETTLE edges after the command.
    logic [SETTLE-1:0] r_pipe_valid;
    logic [SETTLE-1:0] r_pipe_q;

    logic w_check;
    logic w_mismatch;
    logic w_comp_err;
    logic w_forbidden;
    logic w_err_evt;
    logic r_mismatch;
    logic r_comp_err;
    logic r_forbidden;

    assign w_cmd = pack_cmd(i_s, i_r);

    // Next model state from the sampled command
    always_comb begin
        w_state_next = r_state;
        unique case (w_cmd)
            CmdSet:    w_state_next = StSet;
            CmdReset:  w_state_next = StClr;
            CmdForbid: w_state_next = StUnknown;
            CmdHold:   w_state_next = r_state;
            default:   w_state_next = r_state;
        endcase
    end

    assign w_next_valid = (w_state_next != StUnknown);
    assign w_next_q     = (w_state_next == StSet);

    // Model FSM with registered expectation outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StUnknown;
            r_exp_q     <= 1'b0;
            r_exp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_exp_q     <= w_next_q;
            r_exp_valid <= w_next_valid;
        end
    end

    // Expectation delay line, cleared to invalid on reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_valid <= '0;
            r_pipe_q     <= '0;
        end else begin
            r_pipe_valid[0] <= w_next_valid;
            r_pipe_q[0]     <= w_next_q;
            for (int i = 1; i < int'(SETTLE); i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_q[i]     <= r_pipe_q[i-1];
            end
        end
    end

    assign w_check     = i_en && r_pipe_valid[SETTLE-1];
    assign w_mismatch  = w_check && (i_q != r_pipe_q[SETTLE-1]);
    assign w_comp_err  = w_check && (i_q == i_qn);
    assign w_forbidden = i_en && (w_cmd == CmdForbid);
    // A cycle with both faults is a single error event
    assign w_err_evt   = w_mismatch || w_comp_err;

    // Registered one-cycle event pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mismatch  <= 1'b0;
            r_comp_err  <= 1'b0;
            r_forbidden <= 1'b0;
        end else begin
            r_mismatch  <= w_mismatch;
            r_comp_err  <= w_comp_err;
            r_forbidden <= w_forbidden;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_inc   (w_err_evt),
        .o_count (o_err_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_forb_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_inc   (w_forbidden),
        .o_count (o_forb_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_chk_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_inc   (w_check),
        .o_count (o_chk_count)
    );

    assign o_exp_q     = r_exp_q;
    assign o_exp_valid = r_exp_valid;
    assign o_mismatch  = r_mismatch;
    assign o_comp_err  = r_comp_err;
    assign o_forbidden = r_forbidden;

endmodule
